mux_n_to_1_stream: RTL and testbench

MUX_N_TO_1_STREAM -- requirements
Module: mux_n_to_1_stream

---
 rtl/mux_n_to_1_stream.sv | 114 +++++++++++
 tb/tb_mux_n_to_1_stream.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mux_n_to_1_stream.sv
// mux_n_to_1_stream: N-to-1 valid/ready stream mux with fixed or round-robin select and one output register stage
//
// Ports:
//   i_clk, i_rst      clock and asynchronous active-high reset
//   i_data, i_valid   flattened per-channel data (channel k at [k*WIDTH +: WIDTH]) and valids
//   o_ready           per-channel accept, at most one bit high per cycle
//   i_mode, i_sel     0 = fixed select on i_sel, 1 = round-robin arbitration
//   o_data, o_valid   registered output word and its valid
//   o_sel             index of the channel whose data is held in o_data
//   i_ready           downstream accept
//   o_xfer_count      16-bit completed output transfer count, only with MUX_STREAM_XFER_COUNT_EN defined
module mux_n_to_1_stream #(
    parameter int WIDTH = 32,
    parameter int CHANNELS = 4,
    localparam int SEL_W = $clog2(CHANNELS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic [CHANNELS-1:0]       i_valid,
    output logic [CHANNELS-1:0]       o_ready,
    input  logic                      i_mode,
    input  logic [SEL_W-1:0]          i_sel,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_valid,
    output logic [SEL_W-1:0]          o_sel,
    input  logic                      i_ready
`ifdef MUX_STREAM_XFER_COUNT_EN
    ,
    output logic [15:0]               o_xfer_count
`endif
);
    logic [WIDTH-1:0]    o_data_q, o_data_d;
    logic                o_valid_q, o_valid_d;
    logic [SEL_W-1:0]    o_sel_q, o_sel_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                load_en;
    logic                accept;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    gnt_idx;
    logic [WIDTH-1:0]    gnt_data;
    logic [SEL_W-1:0]    rr_nxt;
    assign load_en = ~o_valid_q | i_ready;
    // Grant is one-hot; an out-of-range fixed select matches no channel so nothing is granted.
    always_comb begin
        int j;
        logic found;
        grant = '0;
        found = 1'b0;
        j = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!i_mode) begin
                grant[i] = (int'(i_sel) == i) && i_valid[i];
            end else begin
                j = int'(rr_ptr_q) + i;
                if (j >= CHANNELS) j = j - CHANNELS;
                if (!found && i_valid[j]) begin
                    grant[j] = 1'b1;
                    found = 1'b1;
                end
            end
        end
    end
    // OR-reduce over the one-hot grant so no out-of-range part-select is ever formed.
    always_comb begin
        gnt_idx = '0;
        gnt_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant[k]) begin
                gnt_idx = gnt_idx | SEL_W'(k);
                gnt_data = gnt_data | i_data[k*WIDTH +: WIDTH];
            end
        end
    end
    assign accept = (|grant) & load_en & ~i_rst;
    assign o_ready = grant & {CHANNELS{load_en & ~i_rst}};
    assign rr_nxt = (int'(gnt_idx) == CHANNELS - 1) ? '0 : gnt_idx + 1'b1;
    always_comb begin
        o_valid_d = load_en ? accept : o_valid_q;
        o_data_d = accept ? gnt_data : o_data_q;
        o_sel_d = accept ? gnt_idx : o_sel_q;
        rr_ptr_d = (accept && i_mode) ? rr_nxt : rr_ptr_q;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid_q <= 1'b0;
            o_data_q <= '0;
            o_sel_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q <= o_data_d;
            o_sel_q <= o_sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end
    assign o_data = o_data_q;
    assign o_valid = o_valid_q;
    assign o_sel = o_sel_q;
`ifdef MUX_STREAM_XFER_COUNT_EN
    logic [15:0] xfer_count_q, xfer_count_d;
    always_comb begin
        xfer_count_d = xfer_count_q + 16'(o_valid_q & i_ready);
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            xfer_count_q <= '0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end
    assign o_xfer_count = xfer_count_q;
`endif
endmodule

// File: tb/tb_mux_n_to_1_stream.sv
// tb_mux_n_to_1_stream: directed and random checks of mux_n_to_1_stream against a queue-free behavioural model
module tb_mux_n_to_1_stream;
    localparam int W = 32;
    localparam int CH = 4;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH*W-1:0] data = '0;
    logic [CH-1:0] valid = '0;
    logic [CH-1:0] o_ready;
    logic          mode = 1'b0;
    logic [1:0]    sel = '0;
    logic [W-1:0]  o_data;
    logic          o_valid;
    logic [1:0]    o_sel;
    logic          ready = 1'b0;
`ifdef MUX_STREAM_XFER_COUNT_EN
    logic [15:0]   o_xfer_count;
    logic [15:0]   o_xfer_count3;
`endif
    logic [23:0]   data3 = 24'hABCDEF;
    logic [2:0]    o_ready3;
    logic [7:0]    o_data3;
    logic          o_valid3;
    logic [1:0]    o_sel3;
    int checks = 0;
    int errors = 0;
    int m_ptr = 0;
    int m_sel = 0;
    int m_cnt = 0;
    logic m_valid = 1'b0;
    logic [W-1:0] m_data = '0;
    always #5 clk = ~clk;
    mux_n_to_1_stream #(.WIDTH(W), .CHANNELS(CH)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .o_ready(o_ready),
        .i_mode(mode), .i_sel(sel), .o_data(o_data), .o_valid(o_valid), .o_sel(o_sel),
        .i_ready(ready)
`ifdef MUX_STREAM_XFER_COUNT_EN
        , .o_xfer_count(o_xfer_count)
`endif
    );
    mux_n_to_1_stream #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_data(data3), .i_valid(3'b111), .o_ready(o_ready3),
        .i_mode(1'b0), .i_sel(2'd3), .o_data(o_data3), .o_valid(o_valid3), .o_sel(o_sel3),
        .i_ready(1'b1)
`ifdef MUX_STREAM_XFER_COUNT_EN
        , .o_xfer_count(o_xfer_count3)
`endif
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic int model_gnt();
        if (!mode) return valid[sel] ? int'(sel) : -1;
        for (int i = 0; i < CH; i++) begin
            if (valid[(m_ptr + i) % CH]) return (m_ptr + i) % CH;
        end
        return -1;
    endfunction
    task automatic step();
        int g;
        logic le;
        logic [CH-1:0] er;
        g = model_gnt();
        le = !m_valid || ready;
        er = (g >= 0 && le) ? CH'(1 << g) : '0;
        #1;
        chk("o_ready", 32'(o_ready), 32'(er));
        chk("oob_o_ready", 32'(o_ready3), 0);
        @(posedge clk);
        if (m_valid && ready) m_cnt++;
        if (g >= 0 && le) begin
            m_valid = 1'b1;
            m_data = data[g*W +: W];
            m_sel = g;
            if (mode) m_ptr = (g + 1) % CH;
        end else if (le) begin
            m_valid = 1'b0;
        end
        #1;
        chk("o_valid", 32'(o_valid), 32'(m_valid));
        chk("o_data", o_data, m_data);
        chk("o_sel", 32'(o_sel), 32'(m_sel));
        chk("oob_o_valid", 32'(o_valid3), 0);
`ifdef MUX_STREAM_XFER_COUNT_EN
        chk("xfer_count", 32'(o_xfer_count), 32'(m_cnt[15:0]));
`endif
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", 32'(o_valid), 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_sel", 32'(o_sel), 0);
        chk("rst_o_ready", 32'(o_ready), 0);
        rst = 1'b0;
        mode = 1'b0;
        sel = 2'd2;
        valid = 4'b1111;
        ready = 1'b1;
        data = {32'h44, 32'h11, 32'h22, 32'h33};
        step();
        chk("fix_o_data", o_data, 32'h11);
        chk("fix_o_sel", 32'(o_sel), 2);
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_seq", 32'(o_sel), 32'(i % 4));
        end
        valid = 4'b0001;
        step();
        valid = 4'b1001;
        step();
        chk("rr_wrap3", 32'(o_sel), 3);
        step();
        chk("rr_wrap0", 32'(o_sel), 0);
        mode = 1'b0;
        sel = 2'd0;
        data[31:0] = 32'hA5;
        step();
        ready = 1'b0;
        data[31:0] = 32'h5A;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_o_ready", 32'(o_ready), 0);
            chk("bp_o_data", o_data, 32'hA5);
        end
        ready = 1'b1;
        step();
        chk("bp_release", o_data, 32'h5A);
        for (int n = 0; n < 400; n++) begin
            mode = 1'($urandom);
            sel = 2'($urandom);
            valid = 4'($urandom);
            ready = $urandom_range(0, 9) < 7;
            for (int k = 0; k < CH; k++) data[k*W +: W] = $urandom;
            step();
        end
        mode = 1'b1;
        valid = 4'b0110;
        ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midrst_o_valid", 32'(o_valid), 0);
        chk("midrst_o_data", o_data, 0);
        chk("midrst_o_sel", 32'(o_sel), 0);
        chk("midrst_o_ready", 32'(o_ready), 0);
`ifdef MUX_STREAM_XFER_COUNT_EN
        chk("midrst_count", 32'(o_xfer_count), 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ptr = 0;
        m_valid = 1'b0;
        m_data = '0;
        m_sel = 0;
        m_cnt = 0;
        valid = 4'b1111;
        ready = 1'b1;
        step();
        chk("post_rst_rr0", 32'(o_sel), 0);
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
